// File: rtl/gp_timer_bank.sv
// rtl/gp_timer_bank.sv - multi-channel compare timer bank with shared prescaler and interrupt
//
// Purpose: N_CHANNELS independent compare timers (periodic or one-shot), one
// shared programmable prescaler, per-channel interrupt status/enable and one
// combined interrupt line. Sits on the CPU memory bus.
//
// Ports:
//   clk        system clock, rising edge
//   resetq     asynchronous active-low reset
//   select     block decode from the top level
//   wr[3:0]    byte write enables (lane i -> data_in[8i+7:8i])
//   addr[5:0]  word address
//   data_in    write data
//   data_out   read data, combinational from addr
//   interrupt  OR of (int_status & int_enable)
module gp_timer_bank #(
    parameter int N_CHANNELS     = 4,
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        select,
    input  logic [3:0]  wr,
    input  logic [5:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        interrupt
);

    localparam logic [5:0] A_STATUS   = 6'd32;
    localparam logic [5:0] A_ENABLE   = 6'd33;
    localparam logic [5:0] A_PRESCALE = 6'd34;

    logic [31:0]               bmask;
    logic                      wr_en;
    logic                      tick;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] psc;
    logic [N_CHANNELS-1:0]     int_status;
    logic [N_CHANNELS-1:0]     int_enable;
    logic [N_CHANNELS-1:0]     event_set;
    logic [2:0]                ctrl_a    [N_CHANNELS];
    logic [WIDTH-1:0]          compare_a [N_CHANNELS];
    logic [WIDTH-1:0]          count_a   [N_CHANNELS];

    assign bmask = {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};
    assign wr_en = select && (wr != 4'd0);

    // Shared prescaler: tick is high on the cycle psc reaches PRESCALE.
    assign tick = (psc == prescale);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            psc      <= '0;
            prescale <= '0;
        end else begin
            if (wr_en && addr == A_PRESCALE) begin
                prescale <= (prescale & ~bmask[PRESCALE_WIDTH-1:0])
                          | (data_in[PRESCALE_WIDTH-1:0] & bmask[PRESCALE_WIDTH-1:0]);
                psc      <= '0;
            end else if (tick) begin
                psc <= '0;
            end else begin
                psc <= psc + PRESCALE_WIDTH'(1);
            end
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        localparam logic [5:0] A_CTRL = 6'(4 * c);

        logic [2:0]       ch_ctrl;   // {use_prescaler, oneshot, enable}
        logic [WIDTH-1:0] ch_cmp;
        logic [WIDTH-1:0] ch_cnt;
        logic             ctrl_we;
        logic             cmp_we;
        logic             cnt_we;
        logic             clr;
        logic             adv;
        logic             hit;

        assign ctrl_we = wr_en && addr == A_CTRL;
        assign cmp_we  = wr_en && addr == A_CTRL + 6'd1;
        assign cnt_we  = wr_en && addr == A_CTRL + 6'd2;
        assign clr     = ctrl_we && wr[0] && data_in[3];
        assign adv     = ch_ctrl[0] && (ch_ctrl[2] ? tick : 1'b1);
        // A COUNT write or clear_count overrides the advance, so no event then.
        assign hit     = adv && !cnt_we && !clr && (ch_cnt == ch_cmp);

        always_ff @(posedge clk or negedge resetq) begin
            if (!resetq) begin
                ch_ctrl <= '0;
                ch_cmp  <= '1;
                ch_cnt  <= '0;
            end else begin
                if (ctrl_we) begin
                    ch_ctrl <= (ch_ctrl & ~bmask[2:0]) | (data_in[2:0] & bmask[2:0]);
                end else if (hit && ch_ctrl[1]) begin
                    ch_ctrl[0] <= 1'b0;
                end
                if (cmp_we) begin
                    ch_cmp <= (ch_cmp & ~bmask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & bmask[WIDTH-1:0]);
                end
                if (cnt_we) begin
                    ch_cnt <= (ch_cnt & ~bmask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & bmask[WIDTH-1:0]);
                end else if (clr) begin
                    ch_cnt <= '0;
                end else if (adv) begin
                    ch_cnt <= hit ? '0 : ch_cnt + WIDTH'(1);
                end
            end
        end

        assign ctrl_a[c]    = ch_ctrl;
        assign compare_a[c] = ch_cmp;
        assign count_a[c]   = ch_cnt;
        assign event_set[c] = hit;
    end

    // Hardware set is OR-ed in after the W1C clear so an event is never lost.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            int_status <= '0;
            int_enable <= '0;
        end else begin
            if (wr_en && addr == A_STATUS) begin
                int_status <= (int_status & ~(data_in[N_CHANNELS-1:0] & bmask[N_CHANNELS-1:0]))
                            | event_set;
            end else begin
                int_status <= int_status | event_set;
            end
            if (wr_en && addr == A_ENABLE) begin
                int_enable <= (int_enable & ~bmask[N_CHANNELS-1:0])
                            | (data_in[N_CHANNELS-1:0] & bmask[N_CHANNELS-1:0]);
            end
        end
    end

    assign interrupt = |(int_status & int_enable);

    always_comb begin
        data_out = '0;
        if (!addr[5]) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (addr[4:2] == 3'(c)) begin
                    case (addr[1:0])
                        2'd0:    data_out = 32'(ctrl_a[c]);
                        2'd1:    data_out = 32'(compare_a[c]);
                        2'd2:    data_out = 32'(count_a[c]);
                        default: data_out = '0;
                    endcase
                end
            end
        end else begin
            case (addr)
                A_STATUS:   data_out = 32'(int_status);
                A_ENABLE:   data_out = 32'(int_enable);
                A_PRESCALE: data_out = 32'(prescale);
                default:    data_out = '0;
            endcase
        end
    end

endmodule
